// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM read-path types: burst size codes and byte-lane mask helper
package dram_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } burst_size_t;

  // Bits of a 64-bit word that carry live bytes for a given burst size.
  function automatic logic [DATA_W-1:0] size_mask(input burst_size_t sz);
    logic [DATA_W-1:0] m;
    case (sz)
      SZ_1B:   m = 64'h0000_0000_0000_00FF;
      SZ_2B:   m = 64'h0000_0000_0000_FFFF;
      SZ_4B:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dram_rdret_mem.sv
// rtl/dram_rdret_mem.sv - read-return entry storage: one write port, one asynchronous read port
module dram_rdret_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Entries need no reset: the owner never exposes a slot it has not written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dram_read_return_queue.sv
// rtl/dram_read_return_queue.sv - DEPTH-entry read-return FIFO with byte masking; DRAM_RDRET_PARITY_EN adds per-entry parity
module dram_read_return_queue
  import dram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_size,
`ifdef DRAM_RDRET_PARITY_EN
  output logic              out_parity,
`endif
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
`ifdef DRAM_RDRET_PARITY_EN
  localparam int ENTRY_W = DATA_W + 3;
`else
  localparam int ENTRY_W = DATA_W + 2;
`endif

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop, drop;
  logic [DATA_W-1:0]  masked_data;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;

  // A pop frees a slot this edge, so a push at full is still accepted.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  assign masked_data = in_data & size_mask(burst_size_t'(in_size));

`ifdef DRAM_RDRET_PARITY_EN
  assign wr_entry = {^masked_data, in_size, masked_data};
`else
  assign wr_entry = {in_size, masked_data};
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear wins, so no loss goes unreported.
      overflow <= drop || (overflow && !clr_ovf);
    end
  end

  dram_rdret_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Head fields are forced to zero while empty, which also covers reset.
  assign out_data = empty ? '0 : rd_entry[DATA_W-1:0];
  assign out_size = empty ? 2'b00 : rd_entry[DATA_W+1:DATA_W];
`ifdef DRAM_RDRET_PARITY_EN
  assign out_parity = empty ? 1'b0 : rd_entry[DATA_W+2];
`endif

endmodule

// File: tb/tb_dram_read_return_queue.sv
// tb/tb_dram_read_return_queue.sv - directed self-checking bench for dram_read_return_queue (DRAM_RDRET_PARITY_EN optional)
module tb_dram_read_return_queue;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_size;
  logic        full, empty, overflow, clr_ovf;
`ifdef DRAM_RDRET_PARITY_EN
  logic        out_parity;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_read_return_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_size    (in_size),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_size   (out_size),
`ifdef DRAM_RDRET_PARITY_EN
    .out_parity (out_parity),
`endif
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_size  = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [63:0] d);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, out_data, d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; in_size = 2'b00;
    out_ready = 1'b0; clr_ovf = 1'b0;
    #3;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_size", 64'(out_size), 64'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // Single byte push: not visible before the edge, visible after.
    in_valid = 1'b1; in_data = 64'h5a; in_size = 2'b00;
    check("no_bypass", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("b1_valid", 64'(out_valid), 64'd1);
    check("b1_data", out_data, 64'h5a);
    check("b1_size", 64'(out_size), 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("b1_pop_empty", 64'(empty), 64'd1);

    // Two byte masking.
    push(64'hFFFF_FFFF_DEAD_E4F9, 2'b01);
    check("mask2_data", out_data, 64'h0000_0000_0000_E4F9);
    check("mask2_size", 64'(out_size), 64'd1);
    pop_expect("mask2_pop", 64'h0000_0000_0000_E4F9);
    check("mask2_empty", 64'(empty), 64'd1);

    // Fill to four, then drop a fifth.
    push(64'h30, 2'b11);
    push(64'h3a, 2'b11);
    push(64'hc806, 2'b11);
    check("fill3_full", 64'(full), 64'd0);
    push(64'h5d22, 2'b11);
    check("fill4_full", 64'(full), 64'd1);
    check("fill4_ovf", 64'(overflow), 64'd0);
    push(64'h1, 2'b11);
    check("drop_full", 64'(full), 64'd1);
    check("drop_ovf", 64'(overflow), 64'd1);
    check("drop_head", out_data, 64'h30);

    // Drop with simultaneous clear keeps the flag.
    clr_ovf = 1'b1;
    push(64'h2, 2'b11);
    clr_ovf = 1'b0;
    check("drop_clr_ovf", 64'(overflow), 64'd1);

    // Push and pop together at full.
    in_valid = 1'b1; in_data = 64'h44a8_74a4_de89_076b; in_size = 2'b11;
    out_ready = 1'b1;
    check("pp_head", out_data, 64'h30);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pp_full", 64'(full), 64'd1);
    pop_expect("pop_3a", 64'h3a);
    pop_expect("pop_c806", 64'hc806);
    pop_expect("pop_5d22", 64'h5d22);
    check("pop_last_size", 64'(out_size), 64'd3);
    pop_expect("pop_new", 64'h44a8_74a4_de89_076b);
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_ovf_held", 64'(overflow), 64'd1);

    // Reset mid-stream with three queued entries, asserted between edges.
    push(64'h11, 2'b00);
    push(64'h22, 2'b00);
    push(64'h33, 2'b00);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    check("arst_data", out_data, 64'd0);
    tick();
    n_rst = 1'b1;
    tick();
    push(64'h77, 2'b10);
    check("post_rst_head", out_data, 64'h77);
    pop_expect("post_rst_pop", 64'h77);
    check("post_rst_empty", 64'(empty), 64'd1);

    // Standalone clear after a fresh overflow.
    for (int i = 0; i < 5; i++) push(64'(i + 1), 2'b00);
    check("ovf2_set", 64'(overflow), 64'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf2_clr", 64'(overflow), 64'd0);
    check("ovf2_head", out_data, 64'h1);
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    check("ovf2_empty", 64'(empty), 64'd1);

`ifdef DRAM_RDRET_PARITY_EN
    push(64'h485f_8108, 2'b10);
    check("par_data", out_data, 64'h485f_8108);
    check("par_bit", 64'(out_parity), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("par_empty", 64'(out_parity), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_read_return_queue.md
DRAM_READ_RETURN_QUEUE -- requirements
Module: dram_read_return_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream dram_data_buffer presents a completed read word this cycle.
REQ-005 The block SHALL have port in_data, input, 64 bits: the captured read word, with byte 0 in bits [7:0].
REQ-006 The block SHALL have port in_size, input, 2 bits: burst_size of the word (00=1 B, 01=2 B, 10=4 B, 11=8 B).
REQ-007 The block SHALL have port out_valid, output, 1 bit: the head entry is available to the host.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the host accepts the head entry.
REQ-009 The block SHALL have port out_data, output, 64 bits: head data, with bytes beyond the size zeroed.
REQ-010 The block SHALL have port out_size, output, 2 bits: head size code.
REQ-011 The block SHALL have ports full and empty, output, 1 bit each: queue occupancy flags.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a word was dropped.
REQ-013 The block SHALL have port clr_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-014 The queue SHALL hold up to DEPTH entries of {data, size}, using write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-015 The queue SHALL push an entry when in_valid=1 and full=0 on the rising edge, with the new entry readable one cycle later; it never bypasses storage in the same cycle.
REQ-016 The queue SHALL pop the head entry when out_valid=1 and out_ready=1 on the rising edge.
REQ-017 A push and a pop in the same cycle SHALL both be performed with count unchanged, including at full (push accepted because a slot frees) and at empty (pop impossible, so the push only).
REQ-018 A push when full=1 and no pop SHALL drop the word, leave pointers and count unchanged, and set overflow on the following edge.
REQ-019 The overflow flag SHALL hold until clr_ovf=1; if a drop and clr_ovf occur in the same cycle, overflow SHALL remain set.
REQ-020 The block SHALL hold out_valid equal to not empty, and out_data and out_size stable while out_valid=1 and out_ready=0.
REQ-021 The block SHALL apply byte masking on write: for size 00 keep [7:0], for 01 keep [15:0], for 10 keep [31:0], for 11 keep all; the remaining bits are stored as zero.
REQ-022 The block SHALL assert full when count==DEPTH and empty when count==0, both from registered count with no combinational path from in_valid or out_ready.

Reset
REQ-023 While n_rst=0, the block SHALL clear pointers and count to 0, set empty=1, full=0, out_valid=0, overflow=0, and out_data=0, out_size=00 immediately, without waiting for clk.
REQ-024 A reset mid-operation SHALL discard all queued entries; the first push after n_rst rises is the head.

Configuration
REQ-025 When macro DRAM_RDRET_PARITY_EN is defined, the block SHALL add output out_parity, 1 bit, giving the even parity (XOR) of the valid bytes of the head entry, computed at push and stored per entry; reset value 0.
REQ-026 When DRAM_RDRET_PARITY_EN is undefined, the block SHALL have no out_parity port and no parity storage.

Structure
REQ-027 Shared package dram_pkg SHALL hold the burst_size_t enum (SZ_1B, SZ_2B, SZ_4B, SZ_8B) and the function that maps a size to a 64-bit byte mask; dram_data_buffer SHALL use the same types.
REQ-028 Storage SHALL be one sub-module, dram_rdret_mem: a DEPTH x (66 bits, or 67 with parity) register array with one write and one asynchronous read port; pointer, count and flag logic stay in the top module.

Verification
REQ-029 Verification SHALL cover: reset, then push 0x5a with size 00 -> next cycle out_valid=1, out_data=0x5a, out_size=00; pop -> empty=1.
REQ-030 Verification SHALL cover: push 0xFFFF_FFFF_DEAD_E4F9 with size 01 -> out_data=0x0000_0000_0000_E4F9.
REQ-031 Verification SHALL cover: with out_ready=0, push 4 words (0x30, 0x3a, 0xc806, 0x5d22), then a 5th word 0x1 -> full=1, overflow=1, pops return the 4 words in order, and 0x1 is never returned.
REQ-032 Verification SHALL cover: queue full with simultaneous push 0x44a874a4de89076b (size 11) and pop -> count stays 4, and the new word is returned last.
REQ-033 Verification SHALL cover: n_rst pulsed low mid-stream with 3 entries queued -> empty=1 and out_valid=0 asynchronously, and overflow=0.
REQ-034 Verification SHALL cover: with DRAM_RDRET_PARITY_EN defined, push 0x485f8108 with size 10 -> out_parity equals the XOR of those 32 bits (=1).
